// File: rtl/store_pkg.sv
// rtl/store_pkg.sv - shared store-path definitions
// Contents: aluSelect store size codes, size_of() byte-count decode, FSM state enum.
package store_pkg;

    localparam logic [5:0] SEL_SB = 6'b010000;
    localparam logic [5:0] SEL_SH = 6'b010001;
    localparam logic [5:0] SEL_SW = 6'b010010;
    localparam logic [5:0] SEL_SD = 6'b010011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LO   = 2'd1,
        ST_HI   = 2'd2
    } storeState_e;

    // Store size in bytes. SD on a 32-bit datapath degrades to a full-width
    // word store; unknown codes are full-width stores.
    function automatic logic [3:0] size_of(input logic [5:0] code, input int xlen);
        case (code)
            SEL_SB:  size_of = 4'd1;
            SEL_SH:  size_of = 4'd2;
            SEL_SW:  size_of = 4'd4;
            SEL_SD:  size_of = (xlen == 64) ? 4'd8 : 4'd4;
            default: size_of = 4'(xlen / 8);
        endcase
    endfunction

endpackage

// File: rtl/store_align_unit_if.sv
// rtl/store_align_unit_if.sv - store request / memory beat bundle
// Request side: req_valid, req_ready, req_addr, req_data, aluSelect.
// Memory side:  mem_valid, mem_ready, mem_addr, mem_wdata, mem_wstrb.
// Status:       done, misalign_err.
// slave = the store unit, master = the pipeline / memory environment.
interface store_align_unit_if #(
    parameter int XLEN = 32,
    parameter int AW   = 32
);
    logic              req_valid;
    logic              req_ready;
    logic [AW-1:0]     req_addr;
    logic [XLEN-1:0]   req_data;
    logic [5:0]        aluSelect;
    logic              mem_valid;
    logic              mem_ready;
    logic [AW-1:0]     mem_addr;
    logic [XLEN-1:0]   mem_wdata;
    logic [XLEN/8-1:0] mem_wstrb;
    logic              done;
    logic              misalign_err;

    modport slave (
        input  req_valid, req_addr, req_data, aluSelect, mem_ready,
        output req_ready, mem_valid, mem_addr, mem_wdata, mem_wstrb, done, misalign_err
    );

    modport master (
        output req_valid, req_addr, req_data, aluSelect, mem_ready,
        input  req_ready, mem_valid, mem_addr, mem_wdata, mem_wstrb, done, misalign_err
    );
endinterface

// File: rtl/store_lane_shift.sv
// rtl/store_lane_shift.sv - combinational byte mask, lane shift and strobe generator
// Ports: data (XLEN) source data, offset (OB) byte offset within a word,
//        size (4) byte count; dataFull (2*XLEN) shifted data over two words,
//        strbFull (2*NB) shifted byte strobes over two words.
module store_lane_shift #(
    parameter  int XLEN = 32,
    localparam int NB   = XLEN / 8,
    localparam int OB   = $clog2(NB)
) (
    input  logic [XLEN-1:0]   data,
    input  logic [OB-1:0]     offset,
    input  logic [3:0]        size,
    output logic [2*XLEN-1:0] dataFull,
    output logic [2*NB-1:0]   strbFull
);

    logic [NB-1:0]   sizeMask;
    logic [XLEN-1:0] masked;

    // Bytes beyond the store size are zeroed before shifting so that every
    // lane with a cleared strobe also carries zero data.
    always_comb begin
        sizeMask = '0;
        masked   = '0;
        for (int i = 0; i < NB; i++) begin
            sizeMask[i]       = (i < int'(size));
            masked[8*i +: 8]  = sizeMask[i] ? data[8*i +: 8] : 8'h00;
        end
        dataFull = {{XLEN{1'b0}}, masked} << {offset, 3'b000};
        strbFull = {{NB{1'b0}}, sizeMask} << offset;
    end

endmodule

// File: rtl/store_align_unit.sv
// rtl/store_align_unit.sv - store data aligner with optional boundary-crossing split
// Ports: clk, reset_n (async active-low); bus (store_align_unit_if.slave) carrying
//        the request handshake, the memory beat handshake, done and misalign_err.
module store_align_unit
    import store_pkg::*;
#(
    parameter int XLEN             = 32,
    parameter int AW               = 32,
    parameter int SPLIT_MISALIGNED = 1
) (
    input logic              clk,
    input logic              reset_n,
    store_align_unit_if.slave bus
);

    localparam int NB = XLEN / 8;
    localparam int OB = $clog2(NB);

    storeState_e state, nextState;

    logic [AW-1:0]     baseAddr;
    logic [2*XLEN-1:0] dataReg;
    logic [2*NB-1:0]   strbReg;
    logic              crossReg;
    logic              doneReg, errReg;

    logic [3:0]        reqSize;
    logic [2*XLEN-1:0] shiftData;
    logic [2*NB-1:0]   shiftStrb;
    logic              reqCross, accept, doneNext, errNext;

    logic              memValid;
    logic [AW-1:0]     memAddr;
    logic [XLEN-1:0]   memWdata;
    logic [NB-1:0]     memWstrb;

    assign reqSize = size_of(bus.aluSelect, XLEN);

    store_lane_shift #(.XLEN(XLEN)) u_laneShift (
        .data     (bus.req_data),
        .offset   (bus.req_addr[OB-1:0]),
        .size     (reqSize),
        .dataFull (shiftData),
        .strbFull (shiftStrb)
    );

    assign reqCross = |shiftStrb[2*NB-1:NB];
    assign accept   = bus.req_valid && (state == ST_IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            baseAddr <= '0;
            dataReg  <= '0;
            strbReg  <= '0;
            crossReg <= 1'b0;
            doneReg  <= 1'b0;
            errReg   <= 1'b0;
        end else begin
            state   <= nextState;
            doneReg <= doneNext;
            errReg  <= errNext;
            if (accept) begin
                baseAddr <= {bus.req_addr[AW-1:OB], {OB{1'b0}}};
                dataReg  <= shiftData;
                strbReg  <= shiftStrb;
                crossReg <= reqCross;
            end
        end
    end

    // Beat outputs decode from state and the captured payload only, so they
    // are zero in IDLE and drop straight back to zero on reset.
    always_comb begin
        nextState = state;
        doneNext  = 1'b0;
        errNext   = 1'b0;
        memValid  = 1'b0;
        memAddr   = '0;
        memWdata  = '0;
        memWstrb  = '0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (reqCross && (SPLIT_MISALIGNED == 0)) begin
                        errNext = 1'b1;
                    end else begin
                        nextState = ST_LO;
                    end
                end
            end
            ST_LO: begin
                memValid = 1'b1;
                memAddr  = baseAddr;
                memWdata = dataReg[XLEN-1:0];
                memWstrb = strbReg[NB-1:0];
                if (bus.mem_ready) begin
                    if (crossReg) begin
                        nextState = ST_HI;
                    end else begin
                        nextState = ST_IDLE;
                        doneNext  = 1'b1;
                    end
                end
            end
            ST_HI: begin
                memValid = 1'b1;
                memAddr  = baseAddr + AW'(NB);
                memWdata = dataReg[2*XLEN-1:XLEN];
                memWstrb = strbReg[2*NB-1:NB];
                if (bus.mem_ready) begin
                    nextState = ST_IDLE;
                    doneNext  = 1'b1;
                end
            end
            default: nextState = ST_IDLE;
        endcase
    end

    assign bus.req_ready    = (state == ST_IDLE);
    assign bus.mem_valid    = memValid;
    assign bus.mem_addr     = memAddr;
    assign bus.mem_wdata    = memWdata;
    assign bus.mem_wstrb    = memWstrb;
    assign bus.done         = doneReg;
    assign bus.misalign_err = errReg;

endmodule

// File: tb/tb_store_align_unit.sv
// tb/tb_store_align_unit.sv - directed self-checking bench for store_align_unit
module tb_store_align_unit;
    import store_pkg::*;

    logic clk = 1'b0;
    logic reset_n;
    int   checks = 0;
    int   errors = 0;
    logic [68:0] beat;

    always #5 clk = ~clk;

    store_align_unit_if #(.XLEN(32), .AW(32)) bs ();
    store_align_unit_if #(.XLEN(32), .AW(32)) bn ();

    store_align_unit #(.XLEN(32), .AW(32), .SPLIT_MISALIGNED(1)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bs.slave)
    );

    store_align_unit #(.XLEN(32), .AW(32), .SPLIT_MISALIGNED(0)) dutNs (
        .clk(clk), .reset_n(reset_n), .bus(bn.slave)
    );

    // Present one request at a falling edge; it is accepted on the next rising edge.
    task automatic sendReq(input bit toNs, input logic [31:0] a, input logic [31:0] d, input logic [5:0] sel);
        @(negedge clk);
        if (toNs) begin
            bn.req_valid = 1'b1; bn.req_addr = a; bn.req_data = d; bn.aluSelect = sel;
        end else begin
            bs.req_valid = 1'b1; bs.req_addr = a; bs.req_data = d; bs.aluSelect = sel;
        end
        @(posedge clk);
        #1;
        bs.req_valid = 1'b0;
        bn.req_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        bs.req_valid = 1'b0; bs.req_addr = '0; bs.req_data = '0; bs.aluSelect = '0; bs.mem_ready = 1'b1;
        bn.req_valid = 1'b0; bn.req_addr = '0; bn.req_data = '0; bn.aluSelect = '0; bn.mem_ready = 1'b1;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        checks++; if (bs.req_ready !== 1'b1) begin errors++; $display("FAIL reset req_ready got %b want 1", bs.req_ready); end
        beat = {bs.mem_valid, bs.mem_addr, bs.mem_wdata, bs.mem_wstrb};
        checks++; if (beat !== 69'h0) begin errors++; $display("FAIL reset beat got %h want 0", beat); end
        checks++; if ({bs.done, bs.misalign_err, bn.done, bn.misalign_err} !== 4'b0000) begin
            errors++; $display("FAIL reset pulses got %b want 0000", {bs.done, bs.misalign_err, bn.done, bn.misalign_err}); end
    endtask

    task automatic test_sb();
        sendReq(1'b0, 32'h0000_1003, 32'hDEADBEEF, SEL_SB);
        @(negedge clk);
        beat = {bs.mem_valid, bs.mem_addr, bs.mem_wdata, bs.mem_wstrb};
        checks++; if (beat !== {1'b1, 32'h0000_1000, 32'hEF00_0000, 4'b1000}) begin errors++; $display("FAIL sb beat got %h want %h", beat, {1'b1, 32'h0000_1000, 32'hEF00_0000, 4'b1000}); end
        checks++; if (bs.req_ready !== 1'b0) begin errors++; $display("FAIL sb req_ready busy got %b want 0", bs.req_ready); end
        @(negedge clk);
        checks++; if ({bs.done, bs.mem_valid} !== 2'b10) begin errors++; $display("FAIL sb done got %b want 10", {bs.done, bs.mem_valid}); end
        @(negedge clk);
        checks++; if ({bs.done, bs.req_ready} !== 2'b01) begin errors++; $display("FAIL sb done_end got %b want 01", {bs.done, bs.req_ready}); end
    endtask

    task automatic test_sh();
        sendReq(1'b0, 32'h0000_2002, 32'hCAFEBABE, SEL_SH);
        @(negedge clk);
        beat = {bs.mem_valid, bs.mem_addr, bs.mem_wdata, bs.mem_wstrb};
        checks++; if (beat !== {1'b1, 32'h0000_2000, 32'hBABE_0000, 4'b1100}) begin errors++; $display("FAIL sh beat got %h want %h", beat, {1'b1, 32'h0000_2000, 32'hBABE_0000, 4'b1100}); end
        @(negedge clk);
        checks++; if (bs.done !== 1'b1) begin errors++; $display("FAIL sh done got %b want 1", bs.done); end
        @(negedge clk);
    endtask

    task automatic test_split();
        sendReq(1'b0, 32'h0000_3001, 32'h12345678, SEL_SW);
        @(negedge clk);
        beat = {bs.mem_valid, bs.mem_addr, bs.mem_wdata, bs.mem_wstrb};
        checks++; if (beat !== {1'b1, 32'h0000_3000, 32'h3456_7800, 4'b1110}) begin errors++; $display("FAIL split beat1 got %h want %h", beat, {1'b1, 32'h0000_3000, 32'h3456_7800, 4'b1110}); end
        @(negedge clk);
        beat = {bs.mem_valid, bs.mem_addr, bs.mem_wdata, bs.mem_wstrb};
        checks++; if (beat !== {1'b1, 32'h0000_3004, 32'h0000_0012, 4'b0001}) begin errors++; $display("FAIL split beat2 got %h want %h", beat, {1'b1, 32'h0000_3004, 32'h0000_0012, 4'b0001}); end
        checks++; if (bs.done !== 1'b0) begin errors++; $display("FAIL split early_done got %b want 0", bs.done); end
        @(negedge clk);
        checks++; if ({bs.done, bs.mem_valid, bs.req_ready} !== 3'b101) begin errors++; $display("FAIL split done got %b want 101", {bs.done, bs.mem_valid, bs.req_ready}); end
        // Halfword straddling the word boundary at its last byte.
        sendReq(1'b0, 32'h0000_3003, 32'hCAFEBABE, SEL_SH);
        @(negedge clk);
        beat = {bs.mem_valid, bs.mem_addr, bs.mem_wdata, bs.mem_wstrb};
        checks++; if (beat !== {1'b1, 32'h0000_3000, 32'hBE00_0000, 4'b1000}) begin errors++; $display("FAIL sh_cross beat1 got %h want %h", beat, {1'b1, 32'h0000_3000, 32'hBE00_0000, 4'b1000}); end
        @(negedge clk);
        beat = {bs.mem_valid, bs.mem_addr, bs.mem_wdata, bs.mem_wstrb};
        checks++; if (beat !== {1'b1, 32'h0000_3004, 32'h0000_00BA, 4'b0001}) begin errors++; $display("FAIL sh_cross beat2 got %h want %h", beat, {1'b1, 32'h0000_3004, 32'h0000_00BA, 4'b0001}); end
        @(negedge clk);
        checks++; if (bs.done !== 1'b1) begin errors++; $display("FAIL sh_cross done got %b want 1", bs.done); end
        @(negedge clk);
    endtask

    task automatic test_no_split();
        sendReq(1'b1, 32'h0000_3001, 32'h12345678, SEL_SW);
        @(negedge clk);
        checks++; if ({bn.mem_valid, bn.misalign_err, bn.done, bn.req_ready} !== 4'b0101) begin
            errors++; $display("FAIL nosplit err got %b want 0101", {bn.mem_valid, bn.misalign_err, bn.done, bn.req_ready}); end
        @(negedge clk);
        checks++; if ({bn.mem_valid, bn.misalign_err, bn.done} !== 3'b000) begin
            errors++; $display("FAIL nosplit err_end got %b want 000", {bn.mem_valid, bn.misalign_err, bn.done}); end
        // An aligned word is still stored normally by the non-splitting unit.
        sendReq(1'b1, 32'h0000_3004, 32'h12345678, SEL_SW);
        @(negedge clk);
        beat = {bn.mem_valid, bn.mem_addr, bn.mem_wdata, bn.mem_wstrb};
        checks++; if (beat !== {1'b1, 32'h0000_3004, 32'h1234_5678, 4'b1111}) begin errors++; $display("FAIL nosplit aligned got %h want %h", beat, {1'b1, 32'h0000_3004, 32'h1234_5678, 4'b1111}); end
        @(negedge clk);
        checks++; if ({bn.done, bn.misalign_err} !== 2'b10) begin errors++; $display("FAIL nosplit aligned_done got %b want 10", {bn.done, bn.misalign_err}); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        sendReq(1'b0, 32'h0000_4000, 32'h11223344, 6'b000000);
        @(negedge clk);
        beat = {bs.mem_valid, bs.mem_addr, bs.mem_wdata, bs.mem_wstrb};
        checks++; if (beat !== {1'b1, 32'h0000_4000, 32'h1122_3344, 4'b1111}) begin errors++; $display("FAIL b2b full got %h want %h", beat, {1'b1, 32'h0000_4000, 32'h1122_3344, 4'b1111}); end
        bs.req_valid = 1'b1; bs.req_addr = 32'h0000_5000; bs.req_data = 32'h55667788; bs.aluSelect = SEL_SD;
        @(negedge clk);
        checks++; if ({bs.done, bs.req_ready, bs.mem_valid} !== 3'b110) begin errors++; $display("FAIL b2b idle got %b want 110", {bs.done, bs.req_ready, bs.mem_valid}); end
        @(posedge clk);
        #1;
        bs.req_valid = 1'b0;
        @(negedge clk);
        beat = {bs.mem_valid, bs.mem_addr, bs.mem_wdata, bs.mem_wstrb};
        checks++; if (beat !== {1'b1, 32'h0000_5000, 32'h5566_7788, 4'b1111}) begin errors++; $display("FAIL b2b sd got %h want %h", beat, {1'b1, 32'h0000_5000, 32'h5566_7788, 4'b1111}); end
        @(negedge clk);
        checks++; if ({bs.done, bs.misalign_err} !== 2'b10) begin errors++; $display("FAIL b2b sd_done got %b want 10", {bs.done, bs.misalign_err}); end
        @(negedge clk);
    endtask

    task automatic test_wrap();
        sendReq(1'b0, 32'hFFFF_FFFE, 32'hAABBCCDD, SEL_SW);
        @(negedge clk);
        beat = {bs.mem_valid, bs.mem_addr, bs.mem_wdata, bs.mem_wstrb};
        checks++; if (beat !== {1'b1, 32'hFFFF_FFFC, 32'hCCDD_0000, 4'b1100}) begin errors++; $display("FAIL wrap beat1 got %h want %h", beat, {1'b1, 32'hFFFF_FFFC, 32'hCCDD_0000, 4'b1100}); end
        @(negedge clk);
        beat = {bs.mem_valid, bs.mem_addr, bs.mem_wdata, bs.mem_wstrb};
        checks++; if (beat !== {1'b1, 32'h0000_0000, 32'h0000_AABB, 4'b0011}) begin errors++; $display("FAIL wrap beat2 got %h want %h", beat, {1'b1, 32'h0000_0000, 32'h0000_AABB, 4'b0011}); end
        @(negedge clk);
        checks++; if (bs.done !== 1'b1) begin errors++; $display("FAIL wrap done got %b want 1", bs.done); end
        @(negedge clk);
    endtask

    task automatic test_stall_reset();
        bs.mem_ready = 1'b0;
        sendReq(1'b0, 32'h0000_3001, 32'h12345678, SEL_SW);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            beat = {bs.mem_valid, bs.mem_addr, bs.mem_wdata, bs.mem_wstrb};
            checks++; if (beat !== {1'b1, 32'h0000_3000, 32'h3456_7800, 4'b1110}) begin errors++; $display("FAIL stall lo%0d got %h want %h", i, beat, {1'b1, 32'h0000_3000, 32'h3456_7800, 4'b1110}); end
        end
        bs.mem_ready = 1'b1;
        @(negedge clk);
        bs.mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            beat = {bs.mem_valid, bs.mem_addr, bs.mem_wdata, bs.mem_wstrb};
            checks++; if (beat !== {1'b1, 32'h0000_3004, 32'h0000_0012, 4'b0001}) begin errors++; $display("FAIL stall hi%0d got %h want %h", i, beat, {1'b1, 32'h0000_3004, 32'h0000_0012, 4'b0001}); end
        end
        #2;
        reset_n = 1'b0;
        #1;
        beat = {bs.mem_valid, bs.mem_addr, bs.mem_wdata, bs.mem_wstrb};
        checks++; if ({bs.req_ready, beat} !== {1'b1, 69'h0}) begin errors++; $display("FAIL async_reset got %b/%h want 1/0", bs.req_ready, beat); end
        bs.mem_ready = 1'b1;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        checks++; if ({bs.done, bs.mem_valid, bs.req_ready} !== 3'b001) begin errors++; $display("FAIL reset_no_done got %b want 001", {bs.done, bs.mem_valid, bs.req_ready}); end
    endtask

    initial begin
        test_reset();
        test_sb();
        test_sh();
        test_split();
        test_no_split();
        test_back_to_back();
        test_wrap();
        test_stall_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
